// File: rtl/led_flags_pkg.sv
// Shared types and defaults for the LED write-path flag capture block.
package led_flags_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } clr_state_t;

endpackage : led_flags_pkg

// File: rtl/flag_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous event level.
module flag_sync
  import led_flags_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule : flag_sync

// File: rtl/led_wr_flag_capture.sv
// Captures rising edges of asynchronous LED-panel events into sticky CPU flags,
// with overflow tracking, a one-shot masked clear and a registered interrupt.
module led_wr_flag_capture
  import led_flags_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] event_in,
  input  logic             clr_strobe,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] flags_out,
  output logic [WIDTH-1:0] ovf_out,
  output logic             irq
);

  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_flags_next;
  logic [WIDTH-1:0] w_ovf_next;
  logic             w_armed;

  logic [WIDTH-1:0] r_dly;
  logic [WIDTH-1:0] r_flags;
  logic [WIDTH-1:0] r_ovf;
  logic             r_irq;
  logic [ARM_W-1:0] r_arm;
  clr_state_t       r_state;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sync
      flag_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_async(event_in[gi]),
        .o_sync (w_sync[gi])
      );
    end
  endgenerate

  // Edges are masked until the chains have flushed, so levels high in reset never flag.
  assign w_armed = (r_arm == ARM_DONE);
  assign w_edge  = w_sync & ~r_dly & {WIDTH{w_armed}};

  always_comb begin
    w_clear      = '0;
    if (r_state == IDLE && clr_strobe) begin
      w_clear = clr_mask;
    end
    // A new edge beats a simultaneous clear for the flag, while the overflow stays cleared.
    w_flags_next = (r_flags & ~w_clear) | w_edge;
    w_ovf_next   = (r_ovf & ~w_clear) | (w_edge & r_flags & ~w_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dly   <= '0;
      r_flags <= '0;
      r_ovf   <= '0;
      r_irq   <= 1'b0;
      r_arm   <= '0;
      r_state <= IDLE;
    end else begin
      r_dly   <= w_sync;
      r_flags <= w_flags_next;
      r_ovf   <= w_ovf_next;
      r_irq   <= |(r_flags & irq_mask);
      if (!w_armed) begin
        r_arm <= r_arm + ARM_W'(1);
      end
      case (r_state)
        IDLE:    if (clr_strobe)  r_state <= HOLD;
        HOLD:    if (!clr_strobe) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flags_out = r_flags;
  assign ovf_out   = r_ovf;
  assign irq       = r_irq;

endmodule : led_wr_flag_capture
